aib_calib_slave_seq: RTL and testbench

//  Parametrised AIB slave-side calibration sequencer.
//  - Raises config-done/MAC-ready, waits for master DCC/DLL lock requests on enabled channels.
//  - Then releases adapter reset, lock requests and transfer enables in timed stages.
//  - Supports a channel mask, abort, re-calibration on request drop, and optional timeout.
//  - Sits between the AIB PHY channel array and the AXI-lite bridge init logic.

---
 rtl/aib_calib_pkg.sv | 22 ++
 rtl/aib_calib_dly_cnt.sv | 27 ++
 rtl/aib_calib_slave_seq.sv | 174 +++++++++++++++++
 tb/tb_aib_calib_slave_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/aib_calib_pkg.sv
// Shared types and helpers for the AIB slave-side calibration sequencer.
package aib_calib_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READY    = 3'd1,
    S_WAIT_REQ = 3'd2,
    S_RSTN     = 3'd3,
    S_LOCK     = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } calib_state_t;

  // Bits needed to hold a down-counter preload of (max_val-1); at least 1.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) < max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/aib_calib_dly_cnt.sv
// Loadable down-counter with terminal-count (zero) flag; holds at zero.
module aib_calib_dly_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/aib_calib_slave_seq.sv
// AIB slave-side calibration sequencer: READY -> wait for master lock requests -> timed release.
// Optional wait timeout (S_ERR) is built only when AIB_CALIB_TIMEOUT_EN is defined.
//
// state      | meaning
// S_IDLE     | all outputs low, waiting for i_start
// S_READY    | conf_done and mac_rdy raised, one cycle
// S_WAIT_REQ | waiting for master RX/TX lock requests on all masked channels
// S_RSTN     | adapter reset released, RSTN_DLY cycles
// S_LOCK     | slave lock requests raised, LOCK_DLY cycles
// S_DONE     | transfer enables and calib_done raised, hold
// S_ERR      | wait timeout, leave only through i_start=0
module aib_calib_slave_seq
  import aib_calib_pkg::*;
#(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int RSTN_DLY       = 8,
  parameter int LOCK_DLY       = 16,
  parameter int TIMEOUT        = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [TOTAL_CHNL_NUM-1:0] i_chnl_mask,
  input  logic [TOTAL_CHNL_NUM-1:0] ms_rx_dcc_dll_lock_req,
  input  logic [TOTAL_CHNL_NUM-1:0] ms_tx_dcc_dll_lock_req,
  output logic                      i_conf_done,
  output logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy,
  output logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn,
  output logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req,
  output logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req,
  output logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
  output logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
  output logic                      o_calib_done,
  output logic                      o_calib_err,
  output logic [2:0]                o_state
);

  localparam int N       = TOTAL_CHNL_NUM;
  localparam int DLY_MAX = (RSTN_DLY > LOCK_DLY) ? RSTN_DLY : LOCK_DLY;
  localparam int DLY_W   = cnt_width(DLY_MAX);

  if ((RSTN_DLY < 1) || (LOCK_DLY < 1) || (TIMEOUT < 1)) begin : g_param_chk
    $error("aib_calib_slave_seq: RSTN_DLY, LOCK_DLY and TIMEOUT must be >= 1");
  end

  calib_state_t     state_q, state_d;
  logic [N-1:0]     mask_q, mask_d;
  logic             req_ok;
  logic             dly_load, dly_en, dly_zero;
  logic [DLY_W-1:0] dly_load_val;
  logic             to_expired;
  logic             conf_d, rstn_d, lock_d, xfer_d, err_d;

  assign req_ok = ((ms_rx_dcc_dll_lock_req & mask_q) == mask_q) &&
                  ((ms_tx_dcc_dll_lock_req & mask_q) == mask_q);

  assign dly_en = (state_q == S_RSTN) || (state_q == S_LOCK);

  aib_calib_dly_cnt #(.W(DLY_W)) u_dly_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dly_load),
    .load_val (dly_load_val),
    .en       (dly_en),
    .zero     (dly_zero)
  );

`ifdef AIB_CALIB_TIMEOUT_EN
  localparam int TO_W = cnt_width(TIMEOUT);

  logic to_load, to_en, to_zero;

  // Preload on every entry to S_WAIT_REQ, including re-entry after a request drop.
  assign to_load = (state_d == S_WAIT_REQ) && (state_q != S_WAIT_REQ);
  assign to_en   = (state_q == S_WAIT_REQ);

  aib_calib_dly_cnt #(.W(TO_W)) u_to_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (to_load),
    .load_val (TO_W'(TIMEOUT - 1)),
    .en       (to_en),
    .zero     (to_zero)
  );

  assign to_expired = to_zero;
  assign err_d      = (state_d == S_ERR);
`else
  assign to_expired = 1'b0;
  assign err_d      = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    dly_load     = 1'b0;
    dly_load_val = '0;
    if (!i_start) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_READY;
          mask_d  = i_chnl_mask;
        end
        S_READY:    state_d = S_WAIT_REQ;
        S_WAIT_REQ: begin
          if (req_ok) begin
            state_d      = S_RSTN;
            dly_load     = 1'b1;
            dly_load_val = DLY_W'(RSTN_DLY - 1);
          end else if (to_expired) begin
            state_d = S_ERR;
          end
        end
        S_RSTN: begin
          if (!req_ok) begin
            state_d = S_WAIT_REQ;
          end else if (dly_zero) begin
            state_d      = S_LOCK;
            dly_load     = 1'b1;
            dly_load_val = DLY_W'(LOCK_DLY - 1);
          end
        end
        S_LOCK: begin
          if (!req_ok)       state_d = S_WAIT_REQ;
          else if (dly_zero) state_d = S_DONE;
        end
        S_DONE: begin
          if (!req_ok) state_d = S_WAIT_REQ;
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the entering edge.
  assign conf_d = (state_d != S_IDLE);
  assign rstn_d = (state_d == S_RSTN) || (state_d == S_LOCK) || (state_d == S_DONE);
  assign lock_d = (state_d == S_LOCK) || (state_d == S_DONE);
  assign xfer_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                <= S_IDLE;
      mask_q                 <= '0;
      i_conf_done            <= 1'b0;
      ns_mac_rdy             <= '0;
      ns_adapter_rstn        <= '0;
      sl_rx_dcc_dll_lock_req <= '0;
      sl_tx_dcc_dll_lock_req <= '0;
      sl_rx_transfer_en      <= '0;
      sl_tx_transfer_en      <= '0;
      o_calib_done           <= 1'b0;
      o_calib_err            <= 1'b0;
    end else begin
      state_q                <= state_d;
      mask_q                 <= mask_d;
      i_conf_done            <= conf_d;
      ns_mac_rdy             <= {N{conf_d}} & mask_d;
      ns_adapter_rstn        <= {N{rstn_d}} & mask_d;
      sl_rx_dcc_dll_lock_req <= {N{lock_d}} & mask_d;
      sl_tx_dcc_dll_lock_req <= {N{lock_d}} & mask_d;
      sl_rx_transfer_en      <= {N{xfer_d}} & mask_d;
      sl_tx_transfer_en      <= {N{xfer_d}} & mask_d;
      o_calib_done           <= xfer_d;
      o_calib_err            <= err_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_aib_calib_slave_seq.sv
// Randomized bench for aib_calib_slave_seq against a cycle-count reference model.
module tb_aib_calib_slave_seq;

  localparam int N   = 24;
  localparam int RD  = 8;
  localparam int LD  = 16;
  localparam int TO  = 16;
  localparam int SAT = 1 + RD + LD;
`ifdef AIB_CALIB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [N-1:0] i_chnl_mask = '0;
  logic [N-1:0] ms_rx = '0;
  logic [N-1:0] ms_tx = '0;
  logic         i_conf_done, o_calib_done, o_calib_err;
  logic [N-1:0] ns_mac_rdy, ns_adapter_rstn, sl_rx_lock, sl_tx_lock, sl_rx_xfer, sl_tx_xfer;
  logic [2:0]   o_state;

  always #5 clk = ~clk;

  aib_calib_slave_seq #(
    .TOTAL_CHNL_NUM (N),
    .RSTN_DLY       (RD),
    .LOCK_DLY       (LD),
    .TIMEOUT        (TO)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i_start                (i_start),
    .i_chnl_mask            (i_chnl_mask),
    .ms_rx_dcc_dll_lock_req (ms_rx),
    .ms_tx_dcc_dll_lock_req (ms_tx),
    .i_conf_done            (i_conf_done),
    .ns_mac_rdy             (ns_mac_rdy),
    .ns_adapter_rstn        (ns_adapter_rstn),
    .sl_rx_dcc_dll_lock_req (sl_rx_lock),
    .sl_tx_dcc_dll_lock_req (sl_tx_lock),
    .sl_rx_transfer_en      (sl_rx_xfer),
    .sl_tx_transfer_en      (sl_tx_xfer),
    .o_calib_done           (o_calib_done),
    .o_calib_err            (o_calib_err),
    .o_state                (o_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 ready, 2 calibrating, 3 error.
  // m_seq counts consecutive req_ok edges while calibrating (0 = waiting for requests).
  int           m_mode, m_seq, m_wcnt;
  logic [N-1:0] m_mask;

  task automatic model_reset();
    m_mode = 0; m_seq = 0; m_wcnt = 0; m_mask = '0;
  endtask

  task automatic model_step();
    bit ok;
    ok = ((ms_rx & m_mask) == m_mask) && ((ms_tx & m_mask) == m_mask);
    if (!i_start) begin
      m_mode = 0; m_seq = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_mask = i_chnl_mask; end
        1: begin m_mode = 2; m_seq = 0; m_wcnt = 0; end
        2: begin
          if (ok) begin
            if (m_seq < SAT) m_seq++;
          end else if (m_seq > 0) begin
            m_seq = 0; m_wcnt = 0;
          end else begin
            m_wcnt++;
            if (TO_EN && m_wcnt >= TO) m_mode = 3;
          end
        end
        default: m_mode = 3;
      endcase
    end
  endtask

  task automatic check_all();
    logic [2:0]   e_state;
    logic         e_conf, e_rstn, e_lock, e_xfer;
    logic [N-1:0] e_mac;
    e_conf = (m_mode != 0);
    e_rstn = (m_mode == 2) && (m_seq >= 1);
    e_lock = (m_mode == 2) && (m_seq >= 1 + RD);
    e_xfer = (m_mode == 2) && (m_seq >= SAT);
    e_mac  = e_conf ? m_mask : '0;
    case (m_mode)
      0: e_state = 3'd0;
      1: e_state = 3'd1;
      3: e_state = 3'd6;
      default: e_state = (m_seq == 0) ? 3'd2 : (m_seq < 1 + RD) ? 3'd3 : (m_seq < SAT) ? 3'd4 : 3'd5;
    endcase
    check("state",     32'(o_state),         32'(e_state));
    check("conf_done", 32'(i_conf_done),     32'(e_conf));
    check("mac_rdy",   32'(ns_mac_rdy),      32'(e_mac));
    check("adpt_rstn", 32'(ns_adapter_rstn), 32'(e_rstn ? m_mask : '0));
    check("rx_lock",   32'(sl_rx_lock),      32'(e_lock ? m_mask : '0));
    check("tx_lock",   32'(sl_tx_lock),      32'(e_lock ? m_mask : '0));
    check("rx_xfer",   32'(sl_rx_xfer),      32'(e_xfer ? m_mask : '0));
    check("tx_xfer",   32'(sl_tx_xfer),      32'(e_xfer ? m_mask : '0));
    check("done",      32'(o_calib_done),    32'(e_xfer));
    check("err",       32'(o_calib_err),     32'(m_mode == 3));
  endtask

  task automatic cycle(input logic st, input logic [N-1:0] mk, input logic [N-1:0] rx,
                       input logic [N-1:0] tx);
    i_start = st; i_chnl_mask = mk; ms_rx = rx; ms_tx = tx;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [N-1:0] mk, rx, tx, mk_drv;
    logic         st;
    bit           nocal;
    int           len;

    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Nominal full-mask sequence, then async reset in the middle of S_RSTN.
    mk = '1;
    repeat (30) cycle(1'b1, mk, mk, mk);
    repeat (2) cycle(1'b0, mk, mk, mk);
    repeat (5) cycle(1'b1, mk, mk, mk);
    check("mid_rstn_state", 32'(o_state), 32'd3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(3, 0))
        0: mk = '1;
        1: mk = N'(24'h00000F);
        2: mk = N'($urandom);
        default: mk = '0;
      endcase
      nocal = ($urandom_range(4, 0) == 0);
      len   = 40 + $urandom_range(40, 0);
      repeat (2) cycle(1'b0, mk, '0, '0);
      for (int c = 0; c < len; c++) begin
        st     = ($urandom_range(149, 0) != 0);
        mk_drv = (c == 0) ? mk : N'($urandom);
        if (nocal) begin
          rx = N'($urandom);
          tx = N'($urandom);
        end else begin
          rx = mk | N'($urandom);
          tx = mk | N'($urandom);
          if ($urandom_range(39, 0) == 0) rx[$urandom_range(N-1, 0)] = 1'b0;
          if ($urandom_range(39, 0) == 0) tx[$urandom_range(N-1, 0)] = 1'b0;
        end
        cycle(st, mk_drv, rx, tx);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
